// File: rtl/serial_word_rx_if.sv
// -----------------------------------------------------------------------------
// serial_word_rx_if
//   Parallel word handshake between serial_word_rx and downstream logic.
//
//   Signals
//     O      : received word held in the receiver's holding register
//     valid  : O holds an unconsumed word
//     ready  : downstream accepts O in any cycle where valid and ready are 1
//
//   Modports
//     master : the receiver (drives O/valid, samples ready)
//     slave  : the consumer (samples O/valid, drives ready)
//
//   WIDTH must match the WIDTH of the attached serial_word_rx.
// -----------------------------------------------------------------------------
interface serial_word_rx_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] O;
   logic             valid;
   logic             ready;

   modport master (
      output O,
      output valid,
      input  ready
   );

   modport slave (
      input  O,
      input  valid,
      output ready
   );

endinterface

// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
//   Serial-to-parallel frame receiver. Detects a start bit, shifts in WIDTH
//   data bits (optionally followed by an even parity bit), checks the stop
//   bit and presents the word through a valid/ready holding register.
//
//   Frame : start(0), WIDTH data bits, [even parity], stop(1)
//
//   Parameters
//     WIDTH     : data bits per frame (2 or more)
//     LSB_FIRST : 1 -> first data bit lands in O[0]
//                 0 -> first data bit lands in O[WIDTH-1]
//
//   Ports
//     clk       : clock, all state updates on the rising edge
//     reset     : asynchronous, active-low reset
//     sin       : serial line, idles high, one bit per clock
//     bus       : serial_word_rx_if.master (O, valid out; ready in)
//     frame_err : one-cycle pulse, stop bit was 0, frame discarded
//     overrun   : one-cycle pulse, good frame arrived while the holding
//                 register was full and not being consumed; new word dropped
//     par_err   : one-cycle pulse, parity failure (only with the macro below)
//
//   Configuration macro
//     SERIAL_RX_PARITY_EN : adds the parity bit, the PARITY state and par_err.
//
//   Latency: the stop-bit edge stages the frame outcome; the following edge
//   updates O/valid or raises the error/overrun pulse. The FSM is already
//   back in IDLE on that edge, so a start bit may directly follow a stop bit.
// -----------------------------------------------------------------------------
module serial_word_rx #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   serial_word_rx_if.master bus,
   output logic             frame_err,
   output logic             overrun
`ifdef SERIAL_RX_PARITY_EN
   ,
   output logic             par_err
`endif
);

   localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [WIDTH-1:0] o_q;
   logic             valid_q;
   logic             ferr_q;
   logic             ovr_q;

   // Frame outcome staged on the stop-bit edge, acted on one edge later.
   logic             good_q;
   logic             bad_q;

`ifdef SERIAL_RX_PARITY_EN
   logic             par_q;
   logic             pbad_q;
   logic             perr_q;
`endif

   // Next shift-register value for one incoming data bit.
   always_comb begin
      shift_d = shift_q;
      if (LSB_FIRST) begin
         shift_d = {sin, shift_q[WIDTH-1:1]};
      end else begin
         shift_d = {shift_q[WIDTH-2:0], sin};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         o_q     <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         good_q  <= 1'b0;
         bad_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         par_q   <= 1'b0;
         pbad_q  <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         // Staged outcomes live exactly one cycle.
         good_q <= 1'b0;
         bad_q  <= 1'b0;
         ovr_q  <= 1'b0;
         ferr_q <= bad_q;
`ifdef SERIAL_RX_PARITY_EN
         pbad_q <= 1'b0;
         perr_q <= pbad_q;
`endif

         // Holding register. shift_q is untouched between the stop-bit edge
         // and this edge (a new start bit clears it with a non-blocking
         // update), so it still carries the completed word here.
         if (good_q) begin
            if (!valid_q || bus.ready) begin
               o_q     <= shift_q;
               valid_q <= 1'b1;
            end else begin
               ovr_q   <= 1'b1;
            end
         end else if (valid_q && bus.ready) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (!sin) begin
                  state_q <= S_DATA;
                  shift_q <= '0;
                  cnt_q   <= '0;
               end
            end

            S_DATA: begin
               shift_q <= shift_d;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                  state_q <= S_PARITY;
`else
                  state_q <= S_STOP;
`endif
               end
            end

`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
               par_q   <= sin;
               state_q <= S_STOP;
            end
`endif

            S_STOP: begin
               // A bad stop bit masks any parity verdict.
               if (!sin) begin
                  bad_q  <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
               end else if (^{shift_q, par_q}) begin
                  pbad_q <= 1'b1;
`endif
               end else begin
                  good_q <= 1'b1;
               end
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.O     = o_q;
   assign bus.valid = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
   assign par_err   = perr_q;
`endif

endmodule
